// File: rtl/sr_drive_pkg.sv
// Shared types and widths for the sr_latch push-button driver.
package sr_drive_pkg;

    localparam int unsigned DB_CNT_W    = 8;
    localparam int unsigned PULSE_CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SET_P = 2'd1,
        RST_P = 2'd2,
        GAP   = 2'd3
    } state_t;

endpackage

// File: rtl/sr_debounce.sv
// Two-flop synchronizer, saturating-free debounce counter and rising-edge request
// for one raw push-button input.
module sr_debounce
    import sr_drive_pkg::*;
#(
    parameter int unsigned DB_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic req_c
);

    logic                sync1;
    logic                sync2;
    logic                level;
    logic                level_d;
    logic [DB_CNT_W-1:0] cnt;

    // The level flips on the DB_CYCLES-th consecutive disagreeing sample.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1   <= 1'b0;
            sync2   <= 1'b0;
            level   <= 1'b0;
            level_d <= 1'b0;
            cnt     <= '0;
        end else begin
            sync1   <= raw;
            sync2   <= sync1;
            level_d <= level;
            if (sync2 != level) begin
                if (cnt == DB_CNT_W'(DB_CYCLES - 1)) begin
                    level <= ~level;
                    cnt   <= '0;
                end else begin
                    cnt <= cnt + DB_CNT_W'(1);
                end
            end else begin
                cnt <= '0;
            end
        end
    end

    assign req_c = level & ~level_d;

endmodule

// File: rtl/sr_drive_ctrl.sv
// Debounced set/reset buttons to exclusive, fixed-width s/r pulses for sr_latch.
// Optional SR_DRIVE_MIRROR_EN adds q_mirror, the expected latch state.
module sr_drive_ctrl
    import sr_drive_pkg::*;
#(
    parameter int unsigned DB_CYCLES = 4,
    parameter int unsigned PULSE_W   = 2,
    parameter int unsigned GAP_W     = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic set_raw,
    input  logic reset_raw,
    output logic s,
    output logic r,
    output logic busy,
    output logic conflict
`ifdef SR_DRIVE_MIRROR_EN
    ,
    output logic q_mirror
`endif
);

    logic                   set_req;
    logic                   rst_req;
    state_t                 state;
    state_t                 arb_state;
    logic                   arb_conflict;
    logic                   arb_en;
    logic [PULSE_CNT_W-1:0] cnt;
    logic                   pend_s;
    logic                   pend_r;

    sr_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_set (
        .clk   (clk),
        .rst   (rst),
        .raw   (set_raw),
        .req_c (set_req)
    );

    sr_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_rst (
        .clk   (clk),
        .rst   (rst),
        .raw   (reset_raw),
        .req_c (rst_req)
    );

    // Arbitration runs in IDLE and on the last gap cycle, so a queued pulse
    // follows after exactly GAP_W idle cycles.
    assign arb_en = (state == IDLE) ||
                    ((state == GAP) && (cnt == PULSE_CNT_W'(GAP_W - 1)));

    always_comb begin
        arb_state    = IDLE;
        arb_conflict = 1'b0;
        if (set_req && rst_req) begin
            arb_conflict = 1'b1;
        end else if (set_req) begin
            arb_state = SET_P;
        end else if (rst_req) begin
            arb_state = RST_P;
        end else if (pend_r) begin
            arb_state = RST_P;
        end else if (pend_s) begin
            arb_state = SET_P;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            s        <= 1'b0;
            r        <= 1'b0;
            busy     <= 1'b0;
            conflict <= 1'b0;
            pend_s   <= 1'b0;
            pend_r   <= 1'b0;
`ifdef SR_DRIVE_MIRROR_EN
            q_mirror <= 1'b0;
`endif
        end else begin
            conflict <= 1'b0;
            if (arb_en) begin
                state    <= arb_state;
                cnt      <= '0;
                conflict <= arb_conflict;
                s        <= (arb_state == SET_P);
                r        <= (arb_state == RST_P);
                busy     <= (arb_state != IDLE);
                if (arb_state == SET_P) begin
                    pend_s <= 1'b0;
                end
                if (arb_state == RST_P) begin
                    pend_r <= 1'b0;
                end
`ifdef SR_DRIVE_MIRROR_EN
                if (arb_state == SET_P) begin
                    q_mirror <= 1'b1;
                end else if (arb_state == RST_P) begin
                    q_mirror <= 1'b0;
                end
`endif
            end else begin
                // While busy, requests are remembered but never counted.
                if (set_req && rst_req) begin
                    conflict <= 1'b1;
                end else begin
                    if (set_req) begin
                        pend_s <= 1'b1;
                    end
                    if (rst_req) begin
                        pend_r <= 1'b1;
                    end
                end
                case (state)
                    SET_P, RST_P: begin
                        if (cnt == PULSE_CNT_W'(PULSE_W - 1)) begin
                            state <= GAP;
                            cnt   <= '0;
                            s     <= 1'b0;
                            r     <= 1'b0;
                        end else begin
                            cnt <= cnt + PULSE_CNT_W'(1);
                        end
                    end
                    default: begin
                        cnt <= cnt + PULSE_CNT_W'(1);
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_sr_drive_ctrl.sv
// Bench for sr_drive_ctrl: directed vector tables, multi-cycle corner sequences
// and a randomized run against a behavioural model.
module tb_sr_drive_ctrl;

    localparam int unsigned DB = 4;
    localparam int unsigned PW = 2;
    localparam int unsigned GW = 1;

    logic clk = 1'b0;
    logic rst;
    logic set_raw;
    logic reset_raw;
    logic s;
    logic r;
    logic busy;
    logic conflict;
`ifdef SR_DRIVE_MIRROR_EN
    logic q_mirror;
`endif

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    sr_drive_ctrl #(.DB_CYCLES(DB), .PULSE_W(PW), .GAP_W(GW)) dut (
        .clk       (clk),
        .rst       (rst),
        .set_raw   (set_raw),
        .reset_raw (reset_raw),
        .s         (s),
        .r         (r),
        .busy      (busy),
        .conflict  (conflict)
`ifdef SR_DRIVE_MIRROR_EN
        ,
        .q_mirror  (q_mirror)
`endif
    );

    typedef struct {
        logic set_in;
        logic rst_in;
        logic s;
        logic r;
        logic busy;
        logic conflict;
    } vec_t;

    vec_t tbl[$];

    task automatic check(input string name, input int cyc, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s cyc=%0d: got %0b expected %0b", name, cyc, act, exp);
        end
    endtask

    // Drive inputs, let one rising edge pass, return 1 time unit later.
    task automatic step(input logic si, input logic ri);
        set_raw   = si;
        reset_raw = ri;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        set_raw   = 1'b0;
        reset_raw = 1'b0;
        rst       = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic add(input logic si, input logic ri, input logic es, input logic er,
                       input logic eb, input logic ec);
        vec_t v;
        v.set_in = si; v.rst_in = ri; v.s = es; v.r = er; v.busy = eb; v.conflict = ec;
        tbl.push_back(v);
    endtask

    task automatic run_table(input string name);
        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].set_in, tbl[i].rst_in);
            check({name, "_s"}, i, s, tbl[i].s);
            check({name, "_r"}, i, r, tbl[i].r);
            check({name, "_busy"}, i, busy, tbl[i].busy);
            check({name, "_conflict"}, i, conflict, tbl[i].conflict);
        end
        tbl.delete();
    endtask

    // Reference model: raw-sample history per button, and a pulse described by
    // its kind (0 none, 1 set, 2 reset) and age in cycles since it started.
    bit [31:0] hs_s, hs_r;
    bit        lv_s, lv_sp, lv_r, lv_rp;
    int        kind, tau;
    bit        pd_s, pd_r, m_conf, m_q;

    task automatic model_reset();
        hs_s = '0; hs_r = '0;
        lv_s = 0; lv_sp = 0; lv_r = 0; lv_rp = 0;
        kind = 0; tau = 0; pd_s = 0; pd_r = 0; m_conf = 0; m_q = 0;
    endtask

    // Level flips when the DB synchronized samples (2 edges old) all disagree.
    function automatic bit flips(input bit [31:0] h, input bit lv);
        for (int j = 2; j <= int'(DB) + 1; j++) begin
            if (h[j] == lv) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic start_pulse(input int k);
        kind = k;
        tau  = 0;
        if (k == 1) begin pd_s = 0; m_q = 1; end
        else begin pd_r = 0; m_q = 0; end
    endtask

    task automatic model_step(input bit si, input bit ri);
        bit rq_s, rq_r;
        rq_s   = lv_s & ~lv_sp;
        rq_r   = lv_r & ~lv_rp;
        m_conf = 0;
        if (kind == 0 || tau == int'(PW + GW) - 1) begin
            if (rq_s && rq_r) begin m_conf = 1; kind = 0; end
            else if (rq_s) start_pulse(1);
            else if (rq_r) start_pulse(2);
            else if (pd_r) start_pulse(2);
            else if (pd_s) start_pulse(1);
            else kind = 0;
        end else begin
            tau++;
            if (rq_s && rq_r) m_conf = 1;
            else begin
                if (rq_s) pd_s = 1;
                if (rq_r) pd_r = 1;
            end
        end
        lv_sp = lv_s;
        lv_rp = lv_r;
        hs_s  = {hs_s[30:0], si};
        hs_r  = {hs_r[30:0], ri};
        if (flips(hs_s, lv_s)) lv_s = ~lv_s;
        if (flips(hs_r, lv_r)) lv_r = ~lv_r;
    endtask

    initial begin
        bit cur_s, cur_r;
        int hold_s, hold_r;

        rst = 1'b1; set_raw = 1'b0; reset_raw = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_s", 0, s, 1'b0);
        check("reset_r", 0, r, 1'b0);
        check("reset_busy", 0, busy, 1'b0);
        check("reset_conflict", 0, conflict, 1'b0);
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 1'b0);
            check("idle_s", i, s, 1'b0);
            check("idle_r", i, r, 1'b0);
            check("idle_busy", i, busy, 1'b0);
        end

        // Clean set: pulse after edges 6 and 7, busy through the gap at 8.
        repeat (6) add(1, 0, 0, 0, 0, 0);
        repeat (2) add(1, 0, 1, 0, 1, 0);
        add(1, 0, 0, 0, 1, 0);
        repeat (3) add(1, 0, 0, 0, 0, 0);
        repeat (4) add(0, 0, 0, 0, 0, 0);
        run_table("clean");

        // Simultaneous rise: one conflict cycle, no pulse.
        do_reset();
        repeat (6) add(1, 1, 0, 0, 0, 0);
        add(1, 1, 0, 0, 0, 1);
        repeat (3) add(1, 1, 0, 0, 0, 0);
        repeat (4) add(0, 0, 0, 0, 0, 0);
        run_table("simul");

        // Reset request two cycles behind set: s pulse, one gap, r pulse.
        do_reset();
        repeat (2) add(1, 0, 0, 0, 0, 0);
        repeat (4) add(1, 1, 0, 0, 0, 0);
        repeat (2) add(1, 1, 1, 0, 1, 0);
        add(1, 1, 0, 0, 1, 0);
        repeat (2) add(1, 1, 0, 1, 1, 0);
        add(1, 1, 0, 0, 1, 0);
        repeat (2) add(1, 1, 0, 0, 0, 0);
        repeat (2) add(0, 0, 0, 0, 0, 0);
        run_table("queued");

        // Bounce then hold: single pulse 6 edges after the last toggle.
        do_reset();
        for (int i = 0; i < 6; i++) begin
            step(logic'(i % 2 == 0), 1'b0);
            check("bounce_pre_s", i, s, 1'b0);
        end
        for (int i = 0; i < 14; i++) begin
            step(1'b1, 1'b0);
            check("bounce_s", i, s, logic'(i == 6 || i == 7));
            check("bounce_r", i, r, 1'b0);
        end

        // Asynchronous reset in the middle of an s pulse.
        do_reset();
        repeat (7) step(1'b1, 1'b0);
        check("midrst_pre_s", 0, s, 1'b1);
        #2 rst = 1'b1;
        #1;
        check("midrst_s", 0, s, 1'b0);
        check("midrst_busy", 0, busy, 1'b0);
        set_raw = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 1'b0);
            check("midrst_after_s", i, s, 1'b0);
            check("midrst_after_busy", i, busy, 1'b0);
        end

        // Randomized held/bouncing buttons against the model.
        do_reset();
        model_reset();
        cur_s = 0; cur_r = 0; hold_s = 1; hold_r = 1;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if ($urandom_range(0, 40) == 0) begin
                cur_s  = ~cur_s;
                cur_r  = cur_s;
                hold_s = $urandom_range(6, 14);
                hold_r = hold_s;
            end else begin
                if (hold_s == 0) begin
                    cur_s  = bit'($urandom_range(0, 1));
                    hold_s = $urandom_range(1, 12);
                end
                if (hold_r == 0) begin
                    cur_r  = bit'($urandom_range(0, 1));
                    hold_r = $urandom_range(1, 12);
                end
            end
            step(cur_s, cur_r);
            model_step(cur_s, cur_r);
            check("rand_s", cyc, s, logic'(kind == 1 && tau < int'(PW)));
            check("rand_r", cyc, r, logic'(kind == 2 && tau < int'(PW)));
            check("rand_busy", cyc, busy, logic'(kind != 0));
            check("rand_conflict", cyc, conflict, m_conf);
`ifdef SR_DRIVE_MIRROR_EN
            check("rand_q_mirror", cyc, q_mirror, m_q);
`endif
            hold_s--;
            hold_r--;
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
